// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment glyph constants (active-low {g,f,e,d,c,b,a}) and scan-state type.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    GAP = 1'b0,
    ON  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes render as a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (code)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode display scanner with anti-ghosting gap and leading-zero blanking.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int MAX_SB = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int MAXC   = (MAX_SB > 2) ? MAX_SB : 2;
  localparam int CW     = $clog2(MAXC);
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t             state, nstate;
  logic [CW-1:0]           cnt, ncnt;
  logic [IW-1:0]           idx, nidx;
  logic                    first;
  logic [4*NUM_DIGITS-1:0] pend_bcd, com_bcd, ncom_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp, com_dp, ncom_dp;
  logic                    advance;
  logic [3:0]              sel_code;
  logic                    sel_dp, blank, run_zero;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   nan_n;
  logic [6:0]              nseg_n;
  logic                    ndp_n, nframe;

  bcd_to_seg u_dec (
    .code  (sel_code),
    .seg_n (dec_seg)
  );

  always_comb begin
    nstate  = state;
    ncnt    = cnt + 1'b1;
    advance = 1'b0;
    case (state)
      GAP: begin
        if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
          nstate  = ON;
          ncnt    = '0;
          advance = 1'b1;
        end
      end
      ON: begin
        if (cnt == SCAN_LAST) begin
          ncnt = '0;
          if (BLANK_CYCLES == 0) begin
            nstate  = ON;
            advance = 1'b1;
          end else begin
            nstate = GAP;
          end
        end
      end
      default: nstate = GAP;
    endcase

    nidx = idx;
    if (advance && !first)
      nidx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    ncom_bcd = advance ? pend_bcd : com_bcd;
    ncom_dp  = advance ? pend_dp  : com_dp;

    // Walk from the most significant digit down so run_zero means "this digit and all above are 0".
    run_zero = 1'b1;
    sel_code = '0;
    sel_dp   = 1'b0;
    blank    = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned j;
      j = NUM_DIGITS - 1 - k;
      run_zero = run_zero && (ncom_bcd[4*j +: 4] == 4'd0);
      if (nidx == IW'(j)) begin
        sel_code = ncom_bcd[4*j +: 4];
        sel_dp   = ncom_dp[j];
        blank    = lzb_en && run_zero && (j != 0);
      end
    end

    nan_n  = an_n;
    nseg_n = seg_n;
    ndp_n  = dp_n;
    nframe = 1'b0;
    if (advance) begin
      nan_n       = '1;
      nan_n[nidx] = 1'b0;
      nseg_n      = blank ? SEG_OFF : dec_seg;
      ndp_n       = ~sel_dp;
      nframe      = (nidx == '0);
    end else if (state == ON && nstate == GAP) begin
      nan_n  = '1;
      nseg_n = SEG_OFF;
      ndp_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GAP;
      cnt         <= '0;
      idx         <= '0;
      first       <= 1'b1;
      pend_bcd    <= '0;
      pend_dp     <= '0;
      com_bcd     <= '0;
      com_dp      <= '0;
      an_n        <= '1;
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      idx         <= nidx;
      if (advance)
        first <= 1'b0;
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
      end
      com_bcd     <= ncom_bcd;
      com_dp      <= ncom_dp;
      an_n        <= nan_n;
      seg_n       <= nseg_n;
      dp_n        <= ndp_n;
      frame_start <= nframe;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan with NUM_DIGITS=4, SCAN_DIV=3, BLANK_CYCLES=1.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_start;

  int passed = 0;
  int total  = 0;

  bcd_seg_scan #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (3),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .load        (load),
    .lzb_en      (lzb_en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onecold(input int k);
    logic [3:0] v;
    v    = '1;
    v[k] = 1'b0;
    return v;
  endfunction

  task automatic wait_an(input logic [3:0] want, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an_n === want) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fs(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (an_n !== 4'b1111) $display("FAIL reset_an got=%b want=1111", an_n); else passed++;
    total++; if (seg_n !== 7'h7F) $display("FAIL reset_seg got=%h want=7f", seg_n); else passed++;
    total++; if (dp_n !== 1'b1) $display("FAIL reset_dp got=%b want=1", dp_n); else passed++;
    total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b want=0", frame_start); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (an_n !== 4'b1110) $display("FAIL first_slot_an got=%b want=1110", an_n); else passed++;
    total++; if (frame_start !== 1'b1) $display("FAIL first_slot_fs got=%b want=1", frame_start); else passed++;
    @(negedge clk);
    total++; if (an_n !== 4'b1110) $display("FAIL first_slot_hold_an got=%b want=1110", an_n); else passed++;
    total++; if (frame_start !== 1'b0) $display("FAIL fs_pulse_width got=%b want=0", frame_start); else passed++;
  endtask

  task automatic test_load_display();
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit found;
    bcd_in = 16'h1234;
    dp_in  = 4'b0100;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs(found);
    total++; if (!found) $display("FAIL load_fs_timeout got=none want=frame_start"); else passed++;
    for (int k = 0; k < 4; k++) begin
      wait_an(onecold(k), found);
      total++; if (!found) $display("FAIL load_slot%0d_timeout got=%b want=%b", k, an_n, onecold(k)); else passed++;
      total++; if (seg_n !== exp_seg[k]) $display("FAIL load_seg%0d got=%h want=%h", k, seg_n, exp_seg[k]); else passed++;
      total++; if (dp_n !== exp_dp[k]) $display("FAIL load_dp%0d got=%b want=%b", k, dp_n, exp_dp[k]); else passed++;
    end
  endtask

  task automatic test_scan_timing();
    bit found;
    logic [3:0] exp_an;
    logic       exp_fs;
    wait_fs(found);
    total++; if (!found) $display("FAIL timing_fs_timeout got=none want=frame_start"); else passed++;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 16)           exp_an = 4'b1110;
      else if (c % 4 == 3)   exp_an = 4'b1111;
      else                   exp_an = onecold(c / 4);
      exp_fs = (c % 16 == 0);
      total++; if (an_n !== exp_an) $display("FAIL timing_an c=%0d got=%b want=%b", c, an_n, exp_an); else passed++;
      total++; if (frame_start !== exp_fs) $display("FAIL timing_fs c=%0d got=%b want=%b", c, frame_start, exp_fs); else passed++;
      if (c % 4 == 3 && c < 16) begin
        total++; if (seg_n !== 7'h7F) $display("FAIL timing_gap_seg c=%0d got=%h want=7f", c, seg_n); else passed++;
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'hA000};
    logic [6:0]  exp_seg [3][4] = '{'{7'h78, 7'h7F, 7'h7F, 7'h7F},
                                    '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                                    '{7'h40, 7'h40, 7'h40, 7'h3F}};
    bit found;
    lzb_en = 1'b1;
    dp_in  = 4'b0000;
    for (int v = 0; v < 3; v++) begin
      bcd_in = vals[v];
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_fs(found);
      total++; if (!found) $display("FAIL lzb_fs_timeout v=%0d got=none want=frame_start", v); else passed++;
      for (int k = 0; k < 4; k++) begin
        wait_an(onecold(k), found);
        total++; if (!found) $display("FAIL lzb_slot_timeout v=%0d k=%0d got=%b", v, k, an_n); else passed++;
        total++; if (seg_n !== exp_seg[v][k]) $display("FAIL lzb_seg val=%h k=%0d got=%h want=%h", vals[v], k, seg_n, exp_seg[v][k]); else passed++;
      end
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_load_midslot();
    bit found;
    bcd_in = 16'h1234;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs(found);
    total++; if (!found) $display("FAIL mid_fs_timeout got=none want=frame_start"); else passed++;
    wait_an(4'b1101, found);
    total++; if (!found) $display("FAIL mid_slot1_timeout got=%b want=1101", an_n); else passed++;
    total++; if (seg_n !== 7'h30) $display("FAIL mid_cycle1_seg got=%h want=30", seg_n); else passed++;
    @(negedge clk);
    total++; if (seg_n !== 7'h30) $display("FAIL mid_cycle2_seg got=%h want=30", seg_n); else passed++;
    bcd_in = 16'h9999;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    total++; if (seg_n !== 7'h30) $display("FAIL mid_no_tear_seg got=%h want=30", seg_n); else passed++;
    total++; if (an_n !== 4'b1101) $display("FAIL mid_cycle3_an got=%b want=1101", an_n); else passed++;
    wait_an(4'b1011, found);
    total++; if (!found) $display("FAIL mid_slot2_timeout got=%b want=1011", an_n); else passed++;
    total++; if (seg_n !== 7'h10) $display("FAIL mid_next_slot_seg got=%h want=10", seg_n); else passed++;
  endtask

  task automatic test_async_reset();
    bit found;
    wait_an(4'b0111, found);
    total++; if (!found) $display("FAIL areset_slot_timeout got=%b want=0111", an_n); else passed++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (an_n !== 4'b1111) $display("FAIL areset_an got=%b want=1111", an_n); else passed++;
    total++; if (seg_n !== 7'h7F) $display("FAIL areset_seg got=%h want=7f", seg_n); else passed++;
    total++; if (dp_n !== 1'b1) $display("FAIL areset_dp got=%b want=1", dp_n); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(found);
    total++; if (!found) $display("FAIL areset_fs_timeout got=none want=frame_start"); else passed++;
    for (int k = 0; k < 4; k++) begin
      wait_an(onecold(k), found);
      total++; if (!found) $display("FAIL areset_slot%0d_timeout got=%b", k, an_n); else passed++;
      total++; if (seg_n !== 7'h40) $display("FAIL areset_cleared_seg%0d got=%h want=40", k, seg_n); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_scan_timing();
    test_lzb();
    test_load_midslot();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Multiplexed seven-segment display driver that sits downstream of the synchronous BCD counter chain. It snapshots NUM_DIGITS BCD digits plus decimal points and scans them onto a common-anode display, one digit at a time, with a programmable dwell time. An anti-ghosting blank gap separates digit slots. Optional leading-zero blanking is supported, and non-BCD codes are rendered as a dash.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2); digit 0 is least significant
SCAN_DIV, 1000, clk cycles each digit stays lit (>=1)
BLANK_CYCLES, 2, clk cycles with all anodes off between slots (>=0; 0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4*NUM_DIGITS  packed BCD digits; digit k = bcd_in[4k+3:4k]
dp_in  input  NUM_DIGITS  decimal point per digit, active-high
load  input  1  capture bcd_in/dp_in into pending register this edge
lzb_en  input  1  leading-zero blanking enable (level, sampled each slot start)
an_n  output  NUM_DIGITS  anode enables, active-low, one-cold
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  output  1  decimal point, active-low
frame_start  output  1  one-cycle pulse when the digit-0 slot begins

Behaviour:
- Reset (async, rst_n=0): an_n all 1, seg_n=7'h7F, dp_n=1, frame_start=0. Pending and committed digit registers = 0, digit index = 0, prescaler = 0, state = GAP. Assertion mid-scan blanks the display immediately.
- All outputs are registered and update on the same edge as the state/index change.
- FSM has two states:
  - GAP: all anodes off, seg_n=7'h7F, dp_n=1. Held for BLANK_CYCLES cycles, then enters ON. On exit, the index advances (N-1 wraps to 0; the first exit after reset keeps index 0) and pending is committed to display registers. If BLANK_CYCLES=0, GAP is skipped and ON->ON transitions perform the advance and commit directly.
  - ON: an_n[idx]=0, others 1. Held exactly SCAN_DIV cycles, then enters GAP.
- Prescaler: a single counter of width $clog2(max(SCAN_DIV,BLANK_CYCLES,2)). It resets to 0 on every state entry.
- frame_start is 1 in the first ON cycle with idx=0, otherwise 0.
- load: pending <= {bcd_in, dp_in} on any edge where load=1.
  - Committed digits change only at slot start, so a slot never tears.
  - If load coincides with a commit edge, the commit takes the old pending value and the new value lands in pending.
- Decode (in ON state):
  - 0-9 map to the standard glyphs.
  - 10-15 map to a dash (g only, seg_n=7'h3F).
  - Glyph codes in active-low seg_n: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Leading-zero blanking: when lzb_en=1, digit k>0 is blanked (seg_n=7'h7F) if every committed digit k..N-1 equals 0. Digit 0 is never blanked. A code of 10-15 counts as non-zero.
- dp_n = ~dp of the displayed digit in ON state, including blanked digits.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - the 7-bit glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF)
  - the scan-state enum {GAP, ON}
- Sub-module bcd_to_seg: purely combinational. It maps a 4-bit code to active-low seg_n and is reused by other display blocks.
- The FSM, prescaler, index, pending/committed registers and blanking logic live in bcd_seg_scan.

Test Plan:
All tests use NUM_DIGITS=4, SCAN_DIV=3, BLANK_CYCLES=1.
1. Reset, then release rst_n -> while low: an_n=1111, seg_n=7F, dp_n=1. After release: 1 GAP cycle, then an_n=1110 with frame_start=1 for exactly 1 cycle.
2. Pulse load with bcd_in=16'h1234, dp_in=4'b0100 -> next frame shows these values:
   - an_n 1110: seg_n=19 ('4')
   - an_n 1101: seg_n=30
   - an_n 1011: seg_n=24, dp_n=0
   - an_n 0111: seg_n=79
3. Slot timing -> each an_n value is held exactly 3 cycles, followed by 1 cycle of 1111. frame_start period is 16 cycles. Index wraps 3->0.
4. lzb_en=1 with bcd_in=16'h0007 -> digits 3..1 seg_n=7F, digit 0 seg_n=78. With 16'h0000, digit 0 seg_n=40. With 16'hA000, digit 3 seg_n=3F and digits 2..1 show 40.
5. Load 16'h9999 on the 2nd cycle of the digit-1 slot -> the current slot keeps its old glyph. The next slot (digit 2) shows seg_n=10.
6. Assert rst_n=0 mid-slot for 1 cycle -> an_n=1111 asynchronously. Committed digits clear, so the display shows 40 on all digits with lzb_en=0.
